// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the multicycle RV32I core: valid/ready request,
// LATENCY-cycle response, byte-strobed stores, misaligned/out-of-range error flagging.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp;
  logic          acc_wr, acc_err;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_wstrb, mem_we;
  logic [AW-1:0] acc_idx;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q == WAIT);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the commit edge is the acceptance edge, so use the live request there.
  assign acc_wr    = (state_q == IDLE) ? req_write : wr_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 4'b0000;
    case (state_q)
      IDLE: if (accept) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        cnt_d   = 4'(LATENCY - 1);
        err_d   = 1'b0;
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      // cnt_q counts remaining WAIT cycles; leave on the one that brings it to zero
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      err_d = acc_err;
      if (!acc_wr) rdata_d = acc_err ? 32'h0 : mem[acc_idx];
      else if (!acc_err) mem_we = acc_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a write still pending when reset hits is simply never issued.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!reset && mem_we[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=1 and LATENCY=4 instances, vector table, corner-case
// sequences and random traffic against a word-array reference model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_write, req_ready, rsp_valid, rsp_error, busy;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_wstrb;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wstrb(req_wstrb[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]), .busy(busy[0]));

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wstrb(req_wstrb[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]), .busy(busy[1]));

  int checks = 0, errors = 0;
  int lat [2] = '{1, 4};

  // reference: plain word arrays plus the last read value each port returned
  logic [31:0] mdl [2][1024];
  logic [31:0] mdl_rd [2];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rd, output bit er);
    int n;
    bit e;
    logic [31:0] w;
    rd = 32'h0; er = 1'b0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wstrb[d] = strb;
    n = 0;
    while (!req_ready[d] && n < 50) begin step(); n++; end
    if (!req_ready[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed %b, required 1", d, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    step();
    // scramble the bus: the outstanding access must not see it
    req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_wstrb[d] = 4'($urandom);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin step(); n++; end
    chk($sformatf("latency dut%0d", d), n, lat[d]);
    rd = rsp_rdata[d]; er = rsp_error[d];
    e = model_err(addr);
    if (wr && !e) begin
      w = mdl[d][addr[11:2]];
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
      mdl[d][addr[11:2]] = w;
    end
    if (!wr) mdl_rd[d] = e ? 32'h0 : mdl[d][addr[11:2]];
    chk($sformatf("model_err dut%0d a=%h", d, addr), {31'b0, er}, {31'b0, e});
    chk($sformatf("model_rdata dut%0d a=%h", d, addr), rd, mdl_rd[d]);
    step();
    chk($sformatf("pulse_end dut%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
    chk($sformatf("ready_again dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old;
    bit er;
    logic [31:0] a;
    int sel;
    bit exp_busy [5] = '{1, 1, 1, 0, 0};
    bit exp_rv   [5] = '{0, 0, 0, 1, 0};
    bit exp_rdy  [5] = '{0, 0, 0, 0, 1};

    tbl[0]  = '{0, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 0};
    tbl[1]  = '{0, 0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 0};
    tbl[2]  = '{0, 1, 32'h0000_0020, 32'h11223344, 4'hF, 32'hDEADBEEF, 0};
    tbl[3]  = '{0, 1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 0};
    tbl[4]  = '{0, 0, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD, 0};
    tbl[5]  = '{0, 0, 32'h0000_0002, 32'h0,        4'h0, 32'h0000_0000, 1};
    tbl[6]  = '{0, 1, 32'h0000_0000, 32'h0A0B0C0D, 4'hF, 32'h0000_0000, 0};
    tbl[7]  = '{0, 1, 32'h0000_1000, 32'h0000_0005, 4'hF, 32'h0000_0000, 1};
    tbl[8]  = '{0, 0, 32'h0000_0000, 32'h0,        4'h0, 32'h0A0B0C0D, 0};
    tbl[9]  = '{0, 1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h0A0B0C0D, 0};
    tbl[10] = '{0, 0, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD, 0};
    tbl[11] = '{0, 0, 32'hFFFF_FFFC, 32'h0,        4'h0, 32'h0000_0000, 1};
    tbl[12] = '{0, 1, 32'h0000_0FFC, 32'h13579BDF, 4'hF, 32'h0000_0000, 0};
    tbl[13] = '{0, 0, 32'h0000_0FFC, 32'h0,        4'h0, 32'h13579BDF, 0};
    tbl[14] = '{0, 1, 32'h0000_0013, 32'hFFFFFFFF, 4'hF, 32'h13579BDF, 1};
    tbl[15] = '{0, 0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 0};
    tbl[16] = '{1, 1, 32'h0000_0008, 32'h55AA55AA, 4'hF, 32'h0000_0000, 0};
    tbl[17] = '{1, 0, 32'h0000_0008, 32'h0,        4'h0, 32'h55AA55AA, 0};

    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
    step(); step();
    for (int d = 0; d < 2; d++)
      chk($sformatf("ready_in_reset dut%0d", d), {31'b0, req_ready[d]}, 32'd0);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready dut%0d", d), {31'b0, req_ready[d]}, 32'd1);
      chk($sformatf("rst_vld_busy_err dut%0d", d), {29'b0, rsp_valid[d], busy[d], rsp_error[d]}, 32'd0);
      chk($sformatf("rst_rdata dut%0d", d), rsp_rdata[d], 32'h0);
    end

    foreach (tbl[i]) begin
      do_req(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), {31'b0, er}, {31'b0, tbl[i].exp_er});
    end

    // random traffic over words 0..15 plus misaligned and out-of-range addresses
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) do_req(d, 1'b1, 32'(w * 4), $urandom, 4'hF, rd, er);
      for (int k = 0; k < 120; k++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (sel == 1) a = 32'h0000_1000 + 32'($urandom_range(0, 1000) * 4);
        else if (sel == 2) a = 32'hFFFF_F000 | 32'($urandom_range(0, 1023) * 4);
        else               a = 32'($urandom_range(0, 15) * 4);
        do_req(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, er);
      end
    end

    // LATENCY=4 cycle timing with req_valid held high across two accepts
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h10;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("l4 busy c%0d", k + 1), {31'b0, busy[1]}, {31'b0, exp_busy[k]});
      chk($sformatf("l4 rsp_valid c%0d", k + 1), {31'b0, rsp_valid[1]}, {31'b0, exp_rv[k]});
      chk($sformatf("l4 ready c%0d", k + 1), {31'b0, req_ready[1]}, {31'b0, exp_rdy[k]});
      if (exp_rv[k]) chk("l4 rdata", rsp_rdata[1], mdl[1][4]);
      step();
    end
    chk("l4 reaccept busy", {31'b0, busy[1]}, 32'd1);
    req_valid[1] = 1'b0;
    for (int n = 0; n < 40 && !rsp_valid[1]; n++) step();
    chk("l4 second rdata", rsp_rdata[1], mdl[1][4]);
    mdl_rd[1] = mdl[1][4];
    step();

    // reset while a LATENCY=4 write sits in WAIT: write must be discarded
    old = mdl[1][12];
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h30;
    req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'hF;
    step();
    req_valid[1] = 1'b0;
    chk("rstw busy", {31'b0, busy[1]}, 32'd1);
    step();
    chk("rstw no_rsp", {31'b0, rsp_valid[1]}, 32'd0);
    reset = 1'b1;
    step();
    chk("rstw ready_low", {31'b0, req_ready[1]}, 32'd0);
    chk("rstw no_rsp2", {31'b0, rsp_valid[1]}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rstw ready", {31'b0, req_ready[1]}, 32'd1);
    chk("rstw busy_clr", {31'b0, busy[1]}, 32'd0);
    chk("rstw rdata0", rsp_rdata[1], 32'h0);
    mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
    do_req(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er);
    chk("rstw old_value", rd, old);

    // reset during RESP of a LATENCY=1 write: commit already happened
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h34;
    req_wdata[0] = 32'h600DF00D; req_wstrb[0] = 4'hF;
    step();
    req_valid[0] = 1'b0;
    chk("rstr rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    mdl[0][13] = 32'h600DF00D;
    mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
    do_req(0, 1'b0, 32'h34, 32'h0, 4'h0, rd, er);
    chk("rstr committed", rd, 32'h600DF00D);

    // read data holds while idle
    do_req(0, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, er);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold rdata c%0d", k), rsp_rdata[0], 32'h12345678);
      chk($sformatf("hold rsp_valid c%0d", k), {31'b0, rsp_valid[0]}, 32'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Unified instruction/data memory responder serving the multicycle RV32I core's memory requests (instruction fetch, load, store). It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then returns read data or commits a byte-strobed write, and flags misaligned or out-of-range accesses. It sits between the core's address mux (PC or ALU result) and the word-organised memory array.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, synchronous, active-high
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = read (fetch or load)
req_addr  input  32  byte address
req_wdata  input  32  store data, lane-aligned
req_wstrb  input  4  byte enables for stores; bit i enables byte lane i; ignored for reads
rsp_valid  output  1  one-cycle pulse: response complete
rsp_rdata  output  32  read data; held stable until the next request is accepted
rsp_error  output  1  qualifies rsp_valid: access was misaligned or out of range
busy  output  1  high while a request is outstanding (WAIT state)

Behaviour:
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset deasserts. rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, state=IDLE, wait counter=0. The array contents are not reset.
- State machine: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at a rising edge. Latch write, addr, wdata, wstrb. Load counter with LATENCY-1. Go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0, busy=1. Decrement the counter each cycle. When the counter is 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
- Latency: a request accepted at edge E0 produces rsp_valid high in the cycle following edge E0+LATENCY-1. Back-to-back throughput is one request per LATENCY+1 cycles.
- Response data and write commit happen at the edge that enters RESP:
  - Read: rsp_rdata <= mem[word index].
  - Write: each enabled byte lane of mem[word index] <= corresponding byte of the latched wdata. rsp_rdata is unchanged by writes.
- Word index = latched addr[log2(DEPTH_WORDS)+1:2].
- Error rule: rsp_error=1 if latched addr[1:0]!=2'b00, or latched addr >= DEPTH_WORDS*4 (compared at full 32-bit width, no wrap).
  - Error on a write: the write is dropped and the array is unchanged.
  - Error on a read: rsp_rdata <= 0.
  - rsp_error is updated at the same edge as rsp_rdata and is meaningful only while rsp_valid=1. It is cleared at the next acceptance.
- A write with wstrb=4'b0000 completes normally (rsp_valid, no error) with the array unchanged.
- req_* inputs are ignored outside IDLE. Changes after acceptance have no effect on the outstanding access.
- Reset mid-operation (WAIT or RESP): return to IDLE with outputs at reset values.
  - A write not yet committed (reset during WAIT) is discarded.
  - A write committed at the RESP-entry edge remains.
- Only one access is ever outstanding, so no read/write hazard exists within the block.
- Read of a location immediately after a completed write to it returns the new data.

Test Plan:
1. LATENCY=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 -> rsp_valid 1 cycle after each accept. Read rsp_rdata=0xDEADBEEF, rsp_error=0.
2. Byte strobes: word 0x20 holds 0x11223344; write wdata 0xAABBCCDD, wstrb 4'b0101 -> subsequent read returns 0x11BB33DD.
3. LATENCY=4: accept read at edge 0 -> busy=1 and req_ready=0 for 3 cycles, rsp_valid in cycle 4 only. req_valid held high is accepted again in cycle 5.
4. Errors with DEPTH_WORDS=1024:
   - Read 0x0000_0002 -> rsp_error=1, rsp_rdata=0.
   - Write 0x0000_1000 with wdata 0x5 -> rsp_error=1; a read of word 0 afterwards is unchanged.
5. Reset mid-write: LATENCY=4, write 0x30 with 0xCAFEF00D, assert reset during WAIT -> no rsp_valid; after reset, read 0x30 returns the prior value. req_ready=1 one cycle after reset deasserts.
6. Data hold: read 0x40 (value 0x12345678), then leave req_valid low for 10 cycles -> rsp_rdata stays 0x12345678 and rsp_valid stays 0 after its single pulse.
